spi_ctrl_tx: RTL and testbench

SPI controller-side transmitter. It serialises an 8-bit parallel word onto sclk/mosi/cs for the peripheral-side receiver. It supports all four SPI modes (CPOL = mode[1], CPHA = mode[0]) and sends MSB first. It runs on the system clock and derives sclk through a programmable divider.

---
 rtl/spi_ctrl_tx_if.sv | 23 ++
 rtl/spi_ctrl_tx.sv | 148 ++++++++++++++
 tb/tb_spi_ctrl_tx.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ctrl_tx_if.sv
// spi_ctrl_tx_if: parallel-side handshake and SPI bus signals of the SPI transmitter.
interface spi_ctrl_tx_if;
  logic       start;
  logic [1:0] mode;
  logic [7:0] tx_p_dat;
  logic       sclk;
  logic       mosi;
  logic       cs;
  logic       busy;
  logic       done;

  // The SPI controller drives the serial bus and status.
  modport master (
    input  start, mode, tx_p_dat,
    output sclk, mosi, cs, busy, done
  );

  // The user side issues requests and observes the bus.
  modport slave (
    output start, mode, tx_p_dat,
    input  sclk, mosi, cs, busy, done
  );
endinterface

// File: rtl/spi_ctrl_tx.sv
// spi_ctrl_tx: SPI controller-side transmitter. Serialises one byte MSB first
// in any of the four SPI modes, with sclk derived from clk by CLK_DIV.
module spi_ctrl_tx #(
  parameter int CLK_DIV = 4
) (
  input logic           clk,
  input logic           rst_n,
  spi_ctrl_tx_if.master bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_divCnt;
  logic [4:0] r_edgeCnt;
  logic [7:0] r_shiftReg;
  logic [1:0] r_modeQ;
  logic       r_sclk;
  logic       r_mosi;
  logic       r_cs;
  logic       r_busy;
  logic       r_done;

  logic [7:0] w_shiftNext;
  logic [1:0] w_modeNext;
  logic       w_sclkNext;
  logic       w_mosiNext;
  logic       w_csNext;
  logic       w_busyNext;
  logic       w_doneNext;
  logic       w_tick;
  logic       w_toggle;
  logic       w_leading;
  logic       w_lastToggle;

  // A tick ends each CLK_DIV-cycle slot; sclk only moves on ticks in SETUP/SHIFT.
  assign w_tick       = (r_state != IDLE) && (r_divCnt == DIV_LAST);
  assign w_toggle     = w_tick && ((r_state == SETUP) || (r_state == SHIFT));
  assign w_leading    = ~r_edgeCnt[0];
  assign w_lastToggle = (r_edgeCnt == 5'd15);

  assign bus.sclk = r_sclk;
  assign bus.mosi = r_mosi;
  assign bus.cs   = r_cs;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state: each non-IDLE phase advances on a tick; SHIFT leaves after the 16th toggle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_nextState = SETUP;
      SETUP:   if (w_tick) w_nextState = SHIFT;
      SHIFT:   if (w_tick && w_lastToggle) w_nextState = HOLD;
      HOLD:    if (w_tick) w_nextState = GAP;
      GAP:     if (w_tick) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output/datapath next values; every output is registered, so this computes what the next edge loads.
  always_comb begin
    w_sclkNext  = r_sclk;
    w_mosiNext  = r_mosi;
    w_csNext    = r_cs;
    w_busyNext  = r_busy;
    w_doneNext  = 1'b0;
    w_shiftNext = r_shiftReg;
    w_modeNext  = r_modeQ;
    case (r_state)
      IDLE: begin
        w_csNext   = 1'b1;
        w_busyNext = 1'b0;
        w_mosiNext = 1'b0;
        w_sclkNext = bus.mode[1];
        if (bus.start) begin
          w_shiftNext = bus.tx_p_dat;
          w_modeNext  = bus.mode;
          w_csNext    = 1'b0;
          w_busyNext  = 1'b1;
          w_mosiNext  = bus.mode[0] ? 1'b0 : bus.tx_p_dat[7];
        end
      end
      SETUP, SHIFT: begin
        if (w_toggle) begin
          w_sclkNext = ~r_sclk;
          if (!r_modeQ[0] && !w_leading && !w_lastToggle) begin
            w_mosiNext  = r_shiftReg[6];
            w_shiftNext = {r_shiftReg[6:0], 1'b0};
          end else if (r_modeQ[0] && w_leading) begin
            w_mosiNext  = r_shiftReg[7];
            w_shiftNext = {r_shiftReg[6:0], 1'b0};
          end
        end
      end
      HOLD: begin
        w_sclkNext = r_modeQ[1];
        if (w_tick) begin
          w_csNext   = 1'b1;
          w_mosiNext = 1'b0;
          w_doneNext = 1'b1;
        end
      end
      GAP: begin
        if (w_tick) w_busyNext = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset returns the bus to its idle levels at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_divCnt   <= 8'd0;
      r_edgeCnt  <= 5'd0;
      r_shiftReg <= 8'd0;
      r_modeQ    <= 2'd0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_divCnt   <= ((r_state == IDLE) || w_tick) ? 8'd0 : r_divCnt + 8'd1;
      if (r_state == IDLE)
        r_edgeCnt <= 5'd0;
      else if (w_toggle && (r_edgeCnt != 5'd16))
        r_edgeCnt <= r_edgeCnt + 5'd1;
      r_shiftReg <= w_shiftNext;
      r_modeQ    <= w_modeNext;
      r_sclk     <= w_sclkNext;
      r_mosi     <= w_mosiNext;
      r_cs       <= w_csNext;
      r_busy     <= w_busyNext;
      r_done     <= w_doneNext;
    end
  end

endmodule

// File: tb/tb_spi_ctrl_tx.sv
// tb_spi_ctrl_tx: drives two transmitters (CLK_DIV=4 and CLK_DIV=1) and checks
// every frame with a receiver model that decodes the serial bus by SPI rules.
module tb_spi_ctrl_tx;

  localparam int DIV_A = 4;
  localparam int DIV_B = 1;

  logic clk = 1'b0;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  spi_ctrl_tx_if busA ();
  spi_ctrl_tx_if busB ();

  spi_ctrl_tx #(.CLK_DIV(DIV_A)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA.master));
  spi_ctrl_tx #(.CLK_DIV(DIV_B)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB.master));

  // System clock, 10 ns period.
  always #5 clk = ~clk;

  logic [1:0] oCs, oSclk, oMosi, oBusy, oDone;
  assign oCs   = {busB.cs,   busA.cs};
  assign oSclk = {busB.sclk, busA.sclk};
  assign oMosi = {busB.mosi, busA.mosi};
  assign oBusy = {busB.busy, busA.busy};
  assign oDone = {busB.done, busA.done};

  // Scoreboard: expected received bytes per unit, and the mode each frame was started with.
  logic [7:0] expQA[$];
  logic [7:0] expQB[$];
  logic [1:0] tbMode [2];

  // Receiver model state per unit.
  bit         inFrame   [2];
  int         frameCyc  [2];
  int         nToggle   [2];
  int         nSample   [2];
  int         setupViol [2];
  int         busyRun   [2];
  int         glitchCnt [2];
  int         doneCnt   [2];
  logic [7:0] rx        [2];
  logic [1:0] fMode     [2];
  logic       pCs [2], pSclk [2], pMosi [2], pBusy [2];

  function automatic int divOf(input int u);
    return (u == 0) ? DIV_A : DIV_B;
  endfunction

  function automatic int expSize(input int u);
    return (u == 0) ? expQA.size() : expQB.size();
  endfunction

  function automatic logic [7:0] popExp(input int u);
    if (u == 0) return expQA.pop_front();
    return expQB.pop_front();
  endfunction

  task automatic pushExp(input int u, input logic [7:0] d);
    if (u == 0) expQA.push_back(d);
    else        expQB.push_back(d);
  endtask

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  // Receiver model: decodes each frame from cs/sclk/mosi using the mode it was started with.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        inFrame[u] = 1'b0;
        busyRun[u] = 0;
      end else begin
        if ((oCs[u] != pCs[u]) && (oSclk[u] != pSclk[u])) glitchCnt[u]++;
        if (oCs[u] && pCs[u] && oBusy[u] && (oSclk[u] != pSclk[u])) glitchCnt[u]++;
        if (oBusy[u]) busyRun[u]++;
        else if (pBusy[u]) begin
          checkOutput($sformatf("busy_len_u%0d", u), busyRun[u], 18 * divOf(u));
          busyRun[u] = 0;
        end
        if (pCs[u] && !oCs[u]) begin
          inFrame[u]   = 1'b1;
          frameCyc[u]  = 0;
          nToggle[u]   = 0;
          nSample[u]   = 0;
          setupViol[u] = 0;
          rx[u]        = 8'd0;
          fMode[u]     = tbMode[u];
          checkOutput($sformatf("sclk_idle_at_cs_u%0d", u), int'(oSclk[u]), int'(fMode[u][1]));
        end else if (inFrame[u]) begin
          frameCyc[u]++;
        end
        if (inFrame[u] && !oCs[u] && (oSclk[u] != pSclk[u])) begin
          bit leading;
          bit sampleEdge;
          nToggle[u]++;
          leading    = (pSclk[u] == fMode[u][1]);
          sampleEdge = fMode[u][0] ? !leading : leading;
          if (sampleEdge) begin
            rx[u] = {rx[u][6:0], oMosi[u]};
            nSample[u]++;
            if (oMosi[u] != pMosi[u]) setupViol[u]++;
          end
        end
        if (oDone[u]) begin
          doneCnt[u]++;
          if (expSize(u) == 0) begin
            checkOutput($sformatf("unexpected_done_u%0d", u), 1, 0);
          end else begin
            logic [7:0] want;
            want = popExp(u);
            checkOutput($sformatf("rx_data_u%0d", u), int'(rx[u]), int'(want));
            checkOutput($sformatf("samples_u%0d", u), nSample[u], 8);
            checkOutput($sformatf("toggles_u%0d", u), nToggle[u], 16);
            checkOutput($sformatf("done_time_u%0d", u), frameCyc[u], 17 * divOf(u));
            checkOutput($sformatf("setup_viol_u%0d", u), setupViol[u], 0);
            checkOutput($sformatf("done_cs_high_u%0d", u), int'(oCs[u]), 1);
          end
          inFrame[u] = 1'b0;
        end
      end
      pCs[u]   = oCs[u];
      pSclk[u] = oSclk[u];
      pMosi[u] = oMosi[u];
      pBusy[u] = oBusy[u];
    end
  end

  task automatic waitIdle(input int u);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!oBusy[u]) return;
    end
    checkOutput($sformatf("idle_timeout_u%0d", u), 1, 0);
  endtask

  task automatic waitDone(input int u);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (oDone[u]) return;
    end
    checkOutput($sformatf("done_timeout_u%0d", u), 1, 0);
  endtask

  // Starts one frame on unit A and checks the bus one cycle after start is taken.
  task automatic applyStimulus(input logic [1:0] m, input logic [7:0] d, input bit pushIt);
    @(posedge clk); #1;
    busA.mode     = m;
    busA.tx_p_dat = d;
    tbMode[0]     = m;
    repeat (2) @(posedge clk);
    #1;
    busA.start = 1'b1;
    if (pushIt) pushExp(0, d);
    @(posedge clk); #1;
    busA.start = 1'b0;
    checkOutput("start_cs", int'(busA.cs), 0);
    checkOutput("start_busy", int'(busA.busy), 1);
    checkOutput("start_sclk", int'(busA.sclk), int'(m[1]));
    checkOutput("start_mosi", int'(busA.mosi), m[0] ? 0 : int'(d[7]));
  endtask

  // Hard stop in case something never terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    logic [7:0] seq [3];
    logic [1:0] m;
    logic [7:0] d;
    int gap;
    seq[0] = 8'h01; seq[1] = 8'h80; seq[2] = 8'hFF;
    for (int u = 0; u < 2; u++) begin
      tbMode[u] = 2'd0; glitchCnt[u] = 0; doneCnt[u] = 0; busyRun[u] = 0;
      pCs[u] = 1'b1; pSclk[u] = 1'b0; pMosi[u] = 1'b0; pBusy[u] = 1'b0;
    end
    rst_n = 1'b0;
    busA.start = 1'b0; busA.mode = 2'd0; busA.tx_p_dat = 8'd0;
    busB.start = 1'b0; busB.mode = 2'd0; busB.tx_p_dat = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      checkOutput($sformatf("reset_cs_u%0d", u), int'(oCs[u]), 1);
      checkOutput($sformatf("reset_sclk_u%0d", u), int'(oSclk[u]), 0);
      checkOutput($sformatf("reset_mosi_u%0d", u), int'(oMosi[u]), 0);
      checkOutput($sformatf("reset_busy_u%0d", u), int'(oBusy[u]), 0);
      checkOutput($sformatf("reset_done_u%0d", u), int'(oDone[u]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] directed frames on CLK_DIV=%0d", DIV_A);
    applyStimulus(2'd0, 8'hA5, 1'b1);
    waitIdle(0);
    applyStimulus(2'd3, 8'hA5, 1'b1);
    waitIdle(0);
    applyStimulus(2'd1, 8'h3C, 1'b1);
    waitIdle(0);

    applyStimulus(2'd2, 8'h3C, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    busA.tx_p_dat = 8'hFF;
    busA.mode     = 2'd1;
    busA.start    = 1'b1;
    @(posedge clk); #1;
    busA.start = 1'b0;
    checkOutput("midframe_start_busy", int'(busA.busy), 1);
    waitIdle(0);

    $display("[TB] random frames with inputs scrambled mid-frame");
    for (int i = 0; i < 8; i++) begin
      m = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      applyStimulus(m, d, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      busA.tx_p_dat = 8'($urandom);
      busA.mode     = 2'($urandom);
      waitIdle(0);
    end

    $display("[TB] asynchronous reset at toggle 7");
    applyStimulus(2'd0, 8'($urandom), 1'b0);
    repeat (28) @(posedge clk);
    #1;
    checkOutput("prereset_cs", int'(busA.cs), 0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_cs", int'(busA.cs), 1);
    checkOutput("async_reset_sclk", int'(busA.sclk), 0);
    checkOutput("async_reset_busy", int'(busA.busy), 0);
    checkOutput("async_reset_mosi", int'(busA.mosi), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'd0, 8'h81, 1'b1);
    waitIdle(0);

    $display("[TB] back-to-back frames on CLK_DIV=%0d", DIV_B);
    busB.mode     = 2'd0;
    tbMode[1]     = 2'd0;
    busB.tx_p_dat = seq[0];
    pushExp(1, seq[0]);
    @(negedge clk);
    busB.start = 1'b1;
    for (int f = 0; f < 3; f++) begin
      waitDone(1);
      if (f < 2) begin
        busB.tx_p_dat = seq[f+1];
        pushExp(1, seq[f+1]);
        gap = 1;
        for (int i = 0; i < 50 && busB.cs; i++) begin
          @(negedge clk);
          if (busB.cs) gap++;
        end
        checkOutput("b2b_cs_gap", gap, DIV_B + 1);
        if (f == 1) busB.start = 1'b0;
      end
    end
    waitIdle(1);
    repeat (4) @(posedge clk);

    checkOutput("pending_exp_u0", expSize(0), 0);
    checkOutput("pending_exp_u1", expSize(1), 0);
    checkOutput("glitches_u0", glitchCnt[0], 0);
    checkOutput("glitches_u1", glitchCnt[1], 0);
    checkOutput("done_count_u0", doneCnt[0], 13);
    checkOutput("done_count_u1", doneCnt[1], 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
